// File: rtl/lockstep_commit_checker.sv
// -----------------------------------------------------------------------------
// lockstep_commit_checker
//
// N-way lockstep checker for differential simulation. Channel 0 carries the
// commit stream of the reference harness; channels 1..NUM_CH-1 carry the
// streams of the variant harnesses. Each channel feeds a small FIFO so the
// instances may commit at different times. Whenever every FIFO holds a record,
// the heads are compared and popped together. The run ends in a sticky PASS
// or FAIL verdict that holds until reset.
//
// Ports
//   clock          single clock, all logic on posedge
//   reset          synchronous, active-high
//   commit_valid   per-channel commit strobe
//   commit_data    channel k occupies bits [k*WIDTH +: WIDTH]
//   done           per-channel end-of-test indication (pulse or level)
//   max_cycles     cycle budget for the run; 0 means unlimited
//   status         0 = RUN, 1 = PASS, 2 = FAIL
//   fail_reason    0 none, 1 mismatch, 2 overflow, 3 skew timeout,
//                  4 cycle timeout
//   mismatch_mask  bit k set if channel k differed from channel 0 at the
//                  failing compare (bit 0 is always 0)
//   fail_channel   lowest channel index implicated in the failure
//   commit_count   number of records that compared equal
//   cycle_count    cycles spent in RUN
// -----------------------------------------------------------------------------
module lockstep_commit_checker #(
    parameter int NUM_CH     = 2,
    parameter int WIDTH      = 64,
    parameter int DEPTH      = 16,
    parameter int SKEW_LIMIT = 1024,
    parameter int CNT_W      = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       commit_valid,
    input  logic [NUM_CH*WIDTH-1:0] commit_data,
    input  logic [NUM_CH-1:0]       done,
    input  logic [CNT_W-1:0]        max_cycles,
    output logic [1:0]              status,
    output logic [2:0]              fail_reason,
    output logic [NUM_CH-1:0]       mismatch_mask,
    output logic [2:0]              fail_channel,
    output logic [CNT_W-1:0]        commit_count,
    output logic [CNT_W-1:0]        cycle_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(SKEW_LIMIT + 1);

    localparam logic [AW:0]      PTR_ONE   = (AW + 1)'(1);
    localparam logic [SW-1:0]    SKEW_ONE  = SW'(1);
    localparam logic [SW-1:0]    SKEW_LAST = SW'(SKEW_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [2:0] R_NONE     = 3'd0;
    localparam logic [2:0] R_MISMATCH = 3'd1;
    localparam logic [2:0] R_OVERFLOW = 3'd2;
    localparam logic [2:0] R_SKEW     = 3'd3;
    localparam logic [2:0] R_CYCLES   = 3'd4;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    state_t state;

    // FIFO storage is datapath only; emptiness is defined by the pointers,
    // so clearing the pointers on reset is enough to discard the contents.
    logic [WIDTH-1:0]             fifo_mem [NUM_CH][DEPTH];
    logic [NUM_CH-1:0][AW:0]      wr_ptr;
    logic [NUM_CH-1:0][AW:0]      rd_ptr;

    logic [NUM_CH-1:0][WIDTH-1:0] head_p0;
    logic [NUM_CH-1:0]            fifo_empty;
    logic [NUM_CH-1:0]            fifo_full;
    logic [NUM_CH-1:0]            push;
    logic [NUM_CH-1:0]            wr_en;
    logic [NUM_CH-1:0]            ovf;
    logic [NUM_CH-1:0]            neq_p0;
    logic [NUM_CH-1:0]            done_seen;
    logic [SW-1:0]                skew_cnt;

    logic       run;
    logic       pop;
    logic       imbalanced;
    logic       skew_hit;
    logic       timeout;
    logic       pass_ok;
    logic       fail_now;
    logic [2:0] reason_n;
    logic [2:0] chan_n;
    logic [NUM_CH-1:0] mask_n;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [2:0] lowest_set(input logic [NUM_CH-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // ---- stage p0: FIFO status, head compare and event detection ----------
    always_comb begin
        run = (state == ST_RUN);
        for (int k = 0; k < NUM_CH; k++) begin
            fifo_empty[k] = (wr_ptr[k] == rd_ptr[k]);
            // Same slot but opposite wrap bit: writer is a full lap ahead.
            fifo_full[k]  = (wr_ptr[k][AW] != rd_ptr[k][AW]) &&
                            (wr_ptr[k][AW-1:0] == rd_ptr[k][AW-1:0]);
            head_p0[k]    = fifo_mem[k][rd_ptr[k][AW-1:0]];
            push[k]       = run && commit_valid[k];
        end

        pop = run && !(|fifo_empty);

        for (int k = 0; k < NUM_CH; k++) begin
            // A full FIFO accepts a write only when its head leaves this cycle.
            wr_en[k] = push[k] && (!fifo_full[k] || pop);
            ovf[k]   = push[k] && fifo_full[k] && !pop;
        end

        neq_p0[0] = 1'b0;
        for (int k = 1; k < NUM_CH; k++) begin
            neq_p0[k] = pop && (head_p0[k] != head_p0[0]);
        end

        imbalanced = (|fifo_empty) && !(&fifo_empty);
        // Fires in the cycle that brings the imbalance count up to the limit.
        skew_hit   = run && imbalanced && (skew_cnt >= SKEW_LAST);
        // cycle_count + 1 > max_cycles, written without the carry-out bit.
        timeout    = run && (max_cycles != '0) && (cycle_count >= max_cycles);
        pass_ok    = run && (&done_seen) && (&fifo_empty) && !(|push);

        reason_n = R_NONE;
        chan_n   = 3'd0;
        mask_n   = '0;
        if (|neq_p0) begin
            reason_n = R_MISMATCH;
            chan_n   = lowest_set(neq_p0);
            mask_n   = neq_p0;
        end else if (|ovf) begin
            reason_n = R_OVERFLOW;
            chan_n   = lowest_set(ovf);
        end else if (skew_hit) begin
            reason_n = R_SKEW;
            chan_n   = lowest_set(fifo_empty);
        end else if (timeout) begin
            reason_n = R_CYCLES;
        end
        fail_now = (reason_n != R_NONE);
    end

    // ---- stage p1: FIFO storage ---------------------------------------------
    always_ff @(posedge clock) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (wr_en[k]) begin
                fifo_mem[k][wr_ptr[k][AW-1:0]] <= commit_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // ---- stage p1: control state, counters and verdict ----------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_RUN;
            fail_reason   <= R_NONE;
            mismatch_mask <= '0;
            fail_channel  <= 3'd0;
            commit_count  <= '0;
            cycle_count   <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            done_seen     <= '0;
            skew_cnt      <= '0;
        end else if (run) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (wr_en[k]) wr_ptr[k] <= wr_ptr[k] + PTR_ONE;
                if (pop)      rd_ptr[k] <= rd_ptr[k] + PTR_ONE;
            end

            done_seen <= done_seen | done;
            skew_cnt  <= imbalanced ? (skew_cnt + SKEW_ONE) : '0;

            if (pop && !(|neq_p0)) begin
                commit_count <= commit_count + CNT_ONE;
            end

            // The cycle that produces a verdict is not counted, so a timed-out
            // run reports exactly max_cycles.
            if (fail_now) begin
                state         <= ST_FAIL;
                fail_reason   <= reason_n;
                mismatch_mask <= mask_n;
                fail_channel  <= chan_n;
            end else if (pass_ok) begin
                state <= ST_PASS;
            end else begin
                cycle_count <= cycle_count + CNT_ONE;
            end
        end
    end

    assign status = state;

endmodule

// File: tb/tb_lockstep_commit_checker.sv
// -----------------------------------------------------------------------------
// tb_lockstep_commit_checker
//
// Bench for lockstep_commit_checker. Instance u_a (4 channels, depth 4,
// skew limit 8) runs the directed scenarios and a randomized phase, and is
// compared every cycle against a queue-based reference model. Instance u_b
// (3 channels, depth 16, skew limit 16) runs the skewed-but-equal stream.
// -----------------------------------------------------------------------------
module tb_lockstep_commit_checker;

    localparam int NCH = 4;
    localparam int W   = 32;
    localparam int DEP = 4;
    localparam int SKL = 8;
    localparam int CW  = 32;

    localparam int BNCH = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A signals
    logic              a_rst;
    logic [NCH-1:0]    a_valid;
    logic [NCH*W-1:0]  a_data;
    logic [NCH-1:0]    a_done;
    logic [CW-1:0]     a_max;
    logic [1:0]        a_status;
    logic [2:0]        a_reason;
    logic [NCH-1:0]    a_mask;
    logic [2:0]        a_chan;
    logic [CW-1:0]     a_commit;
    logic [CW-1:0]     a_cycle;

    // instance B signals
    logic              b_rst;
    logic [BNCH-1:0]   b_valid;
    logic [BNCH*W-1:0] b_data;
    logic [BNCH-1:0]   b_done;
    logic [CW-1:0]     b_max;
    logic [1:0]        b_status;
    logic [2:0]        b_reason;
    logic [BNCH-1:0]   b_mask;
    logic [2:0]        b_chan;
    logic [CW-1:0]     b_commit;
    logic [CW-1:0]     b_cycle;

    lockstep_commit_checker #(
        .NUM_CH(NCH), .WIDTH(W), .DEPTH(DEP), .SKEW_LIMIT(SKL), .CNT_W(CW)
    ) u_a (
        .clock(clk), .reset(a_rst), .commit_valid(a_valid), .commit_data(a_data),
        .done(a_done), .max_cycles(a_max), .status(a_status), .fail_reason(a_reason),
        .mismatch_mask(a_mask), .fail_channel(a_chan), .commit_count(a_commit),
        .cycle_count(a_cycle)
    );

    lockstep_commit_checker #(
        .NUM_CH(BNCH), .WIDTH(W), .DEPTH(16), .SKEW_LIMIT(16), .CNT_W(CW)
    ) u_b (
        .clock(clk), .reset(b_rst), .commit_valid(b_valid), .commit_data(b_data),
        .done(b_done), .max_cycles(b_max), .status(b_status), .fail_reason(b_reason),
        .mismatch_mask(b_mask), .fail_channel(b_chan), .commit_count(b_commit),
        .cycle_count(b_cycle)
    );

    // reference model of instance A
    logic [W-1:0]    mq [NCH][$];
    int              m_status;
    int              m_reason;
    int              m_chan;
    logic [NCH-1:0]  m_mask;
    logic [NCH-1:0]  m_done;
    longint unsigned m_commit;
    longint unsigned m_cycle;
    int              m_skew;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [NCH-1:0] v);
        int r;
        r = 0;
        for (int i = NCH - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    // One clock edge of the checker, expressed as queue operations.
    task automatic model_step();
        logic [NCH-1:0] empt;
        logic [NCH-1:0] mism;
        logic [NCH-1:0] ovf;
        bit all_ne;
        bit any_ne;
        bit imbal;
        bit pass_c;
        int reason;
        int chan;
        if (a_rst) begin
            for (int k = 0; k < NCH; k++) mq[k].delete();
            m_status = 0; m_reason = 0; m_chan = 0; m_mask = '0; m_done = '0;
            m_commit = 0; m_cycle = 0; m_skew = 0;
            return;
        end
        if (m_status != 0) return;

        for (int k = 0; k < NCH; k++) empt[k] = (mq[k].size() == 0);
        all_ne = (empt == '0);
        any_ne = (empt != {NCH{1'b1}});
        imbal  = (empt != '0) && any_ne;

        mism = '0;
        if (all_ne) begin
            for (int k = 1; k < NCH; k++) if (mq[k][0] != mq[0][0]) mism[k] = 1'b1;
        end
        for (int k = 0; k < NCH; k++) ovf[k] = a_valid[k] && (mq[k].size() == DEP) && !all_ne;

        reason = 0;
        chan   = 0;
        if (mism != '0) begin
            reason = 1; chan = lowest(mism);
        end else if (ovf != '0) begin
            reason = 2; chan = lowest(ovf);
        end else if (imbal && (m_skew + 1 >= SKL)) begin
            reason = 3; chan = lowest(empt);
        end else if ((a_max != 0) && (m_cycle + 1 > longint'(a_max))) begin
            reason = 4;
        end
        pass_c = (m_done == {NCH{1'b1}}) && !any_ne && (a_valid == '0);

        if (all_ne) begin
            for (int k = 0; k < NCH; k++) void'(mq[k].pop_front());
            if (mism == '0) m_commit++;
        end
        for (int k = 0; k < NCH; k++) begin
            if (a_valid[k] && (mq[k].size() < DEP)) mq[k].push_back(a_data[k*W +: W]);
        end
        m_skew = imbal ? m_skew + 1 : 0;
        m_done = m_done | a_done;

        if (reason != 0) begin
            m_status = 2;
            m_reason = reason;
            m_mask   = (reason == 1) ? mism : '0;
            m_chan   = chan;
        end else if (pass_c) begin
            m_status = 1;
        end else begin
            m_cycle++;
        end
    endtask

    task automatic check_model(input string ctx);
        chk({ctx, ".status"}, 64'(a_status), 64'(m_status));
        chk({ctx, ".reason"}, 64'(a_reason), 64'(m_reason));
        chk({ctx, ".mask"},   64'(a_mask),   64'(m_mask));
        chk({ctx, ".chan"},   64'(a_chan),   64'(m_chan));
        chk({ctx, ".commit"}, 64'(a_commit), m_commit);
        chk({ctx, ".cycle"},  64'(a_cycle),  m_cycle);
    endtask

    task automatic step(input string ctx);
        @(posedge clk);
        model_step();
        #1;
        check_model(ctx);
    endtask

    task automatic reset_a();
        a_rst   = 1'b1;
        a_valid = '0;
        a_done  = '0;
        step("rst");
        a_rst = 1'b0;
    endtask

    task automatic check_idle_a(input string ctx);
        chk({ctx, "_status"}, 64'(a_status), 64'd0);
        chk({ctx, "_reason"}, 64'(a_reason), 64'd0);
        chk({ctx, "_mask"},   64'(a_mask),   64'd0);
        chk({ctx, "_chan"},   64'(a_chan),   64'd0);
        chk({ctx, "_commit"}, 64'(a_commit), 64'd0);
        chk({ctx, "_cycle"},  64'(a_cycle),  64'd0);
    endtask

    task automatic equal_stream_a(input logic [W-1:0] base, input string ctx);
        for (int i = 0; i < 3; i++) begin
            a_valid = '1;
            for (int k = 0; k < NCH; k++) a_data[k*W +: W] = base + W'(4 * i);
            step(ctx);
        end
        a_valid = '0;
        a_done  = '1;
        step(ctx);
        a_done = '0;
        for (int i = 0; i < 4; i++) step(ctx);
        chk({ctx, "_status"}, 64'(a_status), 64'd1);
        chk({ctx, "_commit"}, 64'(a_commit), 64'd3);
        chk({ctx, "_reason"}, 64'(a_reason), 64'd0);
    endtask

    initial begin
        logic [W-1:0] rec [8];
        logic [W-1:0] d;
        int len;
        int idx [NCH];

        a_rst = 1'b1; a_valid = '0; a_data = '0; a_done = '0; a_max = '0;
        b_rst = 1'b1; b_valid = '0; b_data = '0; b_done = '0; b_max = '0;

        // reset values
        step("rst");
        check_idle_a("rst");
        a_rst = 1'b0;

        // equal stream
        equal_stream_a(32'h1000, "eq");
        reset_a();

        // mismatch on the third record of channel 2
        for (int i = 0; i < 3; i++) begin
            a_valid = '1;
            for (int k = 0; k < NCH; k++) a_data[k*W +: W] = 32'hBEEF;
            if (i == 2) a_data[2*W +: W] = 32'hDEAD;
            step("mm");
        end
        a_valid = '0;
        chk("mm_before_verdict", 64'(a_status), 64'd0);
        step("mm");
        chk("mm_status", 64'(a_status), 64'd2);
        chk("mm_reason", 64'(a_reason), 64'd1);
        chk("mm_mask",   64'(a_mask),   64'b0100);
        chk("mm_chan",   64'(a_chan),   64'd2);
        chk("mm_commit", 64'(a_commit), 64'd2);
        reset_a();

        // overflow: five pushes on channel 0 only
        a_valid = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            a_data[0 +: W] = 32'h100 + W'(i);
            step("ovf");
        end
        chk("ovf_before", 64'(a_status), 64'd0);
        a_data[0 +: W] = 32'h104;
        step("ovf");
        a_valid = '0;
        chk("ovf_status", 64'(a_status), 64'd2);
        chk("ovf_reason", 64'(a_reason), 64'd2);
        chk("ovf_chan",   64'(a_chan),   64'd0);
        reset_a();

        // full FIFO with simultaneous push and pop is legal
        for (int i = 0; i < 4; i++) begin
            a_valid = (i == 3) ? 4'hF : 4'h1;
            a_data[0 +: W] = 32'h200 + W'(i);
            for (int k = 1; k < NCH; k++) a_data[k*W +: W] = 32'h200;
            step("fpp");
        end
        a_valid = 4'h1;
        a_data[0 +: W] = 32'h204;
        step("fpp");
        a_valid = '0;
        chk("fpp_status", 64'(a_status), 64'd0);
        chk("fpp_commit", 64'(a_commit), 64'd1);
        reset_a();

        // skew timeout: channel 0 pushes once, nobody else ever does
        a_valid = 4'b0001;
        a_data[0 +: W] = 32'h300;
        step("skw");
        a_valid = '0;
        for (int i = 0; i < 7; i++) step("skw");
        chk("skw_before", 64'(a_status), 64'd0);
        step("skw");
        chk("skw_status", 64'(a_status), 64'd2);
        chk("skw_reason", 64'(a_reason), 64'd3);
        chk("skw_chan",   64'(a_chan),   64'd1);
        reset_a();

        // cycle budget
        a_max = 32'd20;
        for (int i = 0; i < 20; i++) step("cyc");
        chk("cyc_before", 64'(a_status), 64'd0);
        step("cyc");
        chk("cyc_status", 64'(a_status), 64'd2);
        chk("cyc_reason", 64'(a_reason), 64'd4);
        chk("cyc_count",  64'(a_cycle),  64'd20);
        for (int i = 0; i < 3; i++) step("cyc");
        chk("cyc_frozen", 64'(a_cycle), 64'd20);

        // reset after a failed run, then a fresh passing run
        a_rst = 1'b1;
        a_max = '0;
        step("rst2");
        check_idle_a("rst2");
        a_rst = 1'b0;
        equal_stream_a(32'h2000, "eq2");
        reset_a();

        // randomized runs
        for (int it = 0; it < 30; it++) begin
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) rec[j] = $urandom;
            for (int k = 0; k < NCH; k++) idx[k] = 0;
            a_max = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(10, 60));
            for (int c = 0; c < 60; c++) begin
                for (int k = 0; k < NCH; k++) begin
                    if ((idx[k] < len) && ($urandom_range(0, 3) != 0)) begin
                        d = rec[idx[k]];
                        if ($urandom_range(0, 39) == 0) d = d ^ (32'h1 << $urandom_range(0, 31));
                        a_valid[k] = 1'b1;
                        a_data[k*W +: W] = d;
                        idx[k]++;
                    end else begin
                        a_valid[k] = 1'b0;
                    end
                    a_done[k] = (idx[k] == len) && ($urandom_range(0, 2) == 0);
                end
                step("rnd");
            end
            reset_a();
        end
        a_max = '0;

        // skewed equal stream on instance B: channel 2 trails by 10 cycles
        a_rst = 1'b1;
        step("bidle");
        b_rst = 1'b0;
        for (int t = 0; t < 13; t++) begin
            b_valid[0] = (t < 3);
            b_valid[1] = (t < 3);
            b_valid[2] = (t >= 10);
            b_data[0 +: W]   = 32'h1000 + W'(4 * t);
            b_data[W +: W]   = 32'h1000 + W'(4 * t);
            b_data[2*W +: W] = 32'h1000 + W'(4 * (t - 10));
            step("bidle");
        end
        b_valid = '0;
        chk("bskew_running", 64'(b_status), 64'd0);
        chk("bskew_nofail",  64'(b_reason), 64'd0);
        b_done = '1;
        step("bidle");
        b_done = '0;
        for (int i = 0; i < 4; i++) step("bidle");
        chk("bskew_status", 64'(b_status), 64'd1);
        chk("bskew_commit", 64'(b_commit), 64'd3);
        chk("bskew_reason", 64'(b_reason), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
